trace_emitter: RTL and testbench

- Synthesizable hardware counterpart of the bench-side cycle dump.
- Counts cycles, load-use stalls and flushes from CPU pipeline control signals.
- Snapshots a per-cycle record (cycle, PC, stall count, flush count) into a small record FIFO.
- Streams records out as 32-bit words over a valid/ready interface, for an on-chip logger or UART bridge sitting beside CPU.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_fifo.sv | 47 ++++
 rtl/trace_emitter.sv | 144 ++++++++++++++
 tb/tb_trace_emitter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the trace emitter: the record layout, the word order
// used when serialising a record, and the sampler state encoding.
package trace_pkg;

    typedef struct packed {
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [31:0] stall;
        logic [31:0] flush;
    } trace_rec_t;

    localparam logic [1:0] W_CYCLE = 2'd0;
    localparam logic [1:0] W_PC    = 2'd1;
    localparam logic [1:0] W_STALL = 2'd2;
    localparam logic [1:0] W_FLUSH = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } samp_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO. Pointers carry one extra wrap bit so that full
// and empty can be told apart. The head entry is read combinationally.
// A push and a pop on the same edge are both honoured, even when full.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  trace_rec_t din_i,
    input  logic       pop_i,
    output trace_rec_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t      mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;

    // Storage write; data array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wptr[AW-1:0]] <= din_i;
        end
    end

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_i) wptr <= wptr + 1'b1;
            if (pop_i)  rptr <= rptr + 1'b1;
        end
    end

    assign head_o  = mem[rptr[AW-1:0]];
    assign empty_o = (wptr == rptr);
    assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/trace_emitter.sv
// Cycle/stall/flush tracer for the CPU pipeline. Each sampling edge
// snapshots a record into a small FIFO; records leave as four 32-bit words
// over a valid/ready stream. Records that find the FIFO full are counted.
module trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       pc_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              flush_i,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [31:0]       trace_data_o,
    output logic [1:0]        trace_word_o,
    output logic              trace_last_o,
    output logic [31:0]       cycle_cnt_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

    samp_state_t       state;
    logic [31:0]       cycle_cnt;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
    logic [DROP_W-1:0] drop_cnt;
    logic [1:0]        word_idx;

    logic       stall_ev;
    logic       flush_ev;
    logic       vld_p0;
    trace_rec_t rec_p0;
    trace_rec_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       xfer;
    logic       pop;
    logic       push_ok;
    logic       drop;

    // A taken branch owns the bubble, so it is not charged as a load-use stall.
    assign stall_ev = stall_i && !branch_i;
    assign flush_ev = flush_i;
    assign vld_p0   = start_i;

    // Stall and flush fields include this edge's event; cycle is pre-increment.
    assign rec_p0.cycle = cycle_cnt;
    assign rec_p0.pc    = pc_i;
    assign rec_p0.stall = stall_cnt + {31'd0, stall_ev};
    assign rec_p0.flush = flush_cnt + {31'd0, flush_ev};

    assign xfer    = trace_valid_o && trace_ready_i;
    assign pop     = xfer && (word_idx == W_FLUSH);
    assign push_ok = vld_p0 && (!fifo_full || pop);
    assign drop    = vld_p0 && fifo_full && !pop;

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_ok),
        .din_i   (rec_p0),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sampler state machine: tracks whether the CPU is running.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_i)  state <= S_RUN;
                S_RUN:   if (!start_i) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Live counters advance only on sampling edges and wrap at 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (vld_p0) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            stall_cnt <= stall_cnt + {31'd0, stall_ev};
            flush_cnt <= flush_cnt + {31'd0, flush_ev};
        end
    end

    // Dropped-record counter sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Word index walks 0..3 on each transfer and wraps as the head pops.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            word_idx <= W_CYCLE;
        end else if (xfer) begin
            word_idx <= word_idx + 2'd1;
        end
    end

    // Select the current word of the head record.
    always_comb begin
        trace_data_o = head.cycle;
        case (word_idx)
            W_CYCLE: trace_data_o = head.cycle;
            W_PC:    trace_data_o = head.pc;
            W_STALL: trace_data_o = head.stall;
            W_FLUSH: trace_data_o = head.flush;
            default: trace_data_o = head.cycle;
        endcase
    end

    assign trace_valid_o = !fifo_empty;
    assign trace_word_o  = word_idx;
    assign trace_last_o  = (word_idx == W_FLUSH);
    assign cycle_cnt_o   = cycle_cnt;
    assign stall_cnt_o   = stall_cnt;
    assign flush_cnt_o   = flush_cnt;
    assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_trace_emitter.sv
// Scoreboard bench for trace_emitter: stimulus queues hand-computed words,
// a monitor pops and compares on every accepted word.
module tb_trace_emitter;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [31:0]       pc_i;
    logic              stall_i;
    logic              branch_i;
    logic              flush_i;
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [31:0]       trace_data_o;
    logic [1:0]        trace_word_o;
    logic              trace_last_o;
    logic [31:0]       cycle_cnt_o;
    logic [31:0]       stall_cnt_o;
    logic [31:0]       flush_cnt_o;
    logic [DROP_W-1:0] drop_cnt_o;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    trace_emitter #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .flush_i       (flush_i),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (trace_ready_i),
        .trace_data_o  (trace_data_o),
        .trace_word_o  (trace_word_o),
        .trace_last_o  (trace_last_o),
        .cycle_cnt_o   (cycle_cnt_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    // Monitor: a word is accepted on the next rising edge when valid && ready here.
    always @(negedge clk) begin
        if (rst_i && trace_valid_o && trace_ready_i) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL stream_unexpected: got data=%h word=%0d last=%0b, required no word",
                         trace_data_o, trace_word_o, trace_last_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (trace_data_o !== e.data || trace_word_o !== e.idx || trace_last_o !== e.last) begin
                    errors++;
                    $display("FAIL stream_word: got data=%h word=%0d last=%0b, required data=%h word=%0d last=%0b",
                             trace_data_o, trace_word_o, trace_last_o, e.data, e.idx, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_rec(input logic [31:0] cyc, input logic [31:0] pc,
                            input logic [31:0] st, input logic [31:0] fl);
        exp_t e;
        e.data = cyc; e.idx = 2'd0; e.last = 1'b0; q.push_back(e);
        e.data = pc;  e.idx = 2'd1; e.last = 1'b0; q.push_back(e);
        e.data = st;  e.idx = 2'd2; e.last = 1'b0; q.push_back(e);
        e.data = fl;  e.idx = 2'd3; e.last = 1'b1; q.push_back(e);
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        start_i = 1'b0;
        trace_ready_i = 1'b0;
        stall_i = 1'b0;
        branch_i = 1'b0;
        flush_i = 1'b0;
        pc_i = '0;
        q.delete();
        step();
        step();
        rst_i = 1'b1;
    endtask

    // Wait, bounded, until every expected word has been seen and the stream is idle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || trace_valid_o) && n < 100) begin
            step();
            n++;
        end
        check({name, "_drained"}, {31'd0, (q.size() != 0 || trace_valid_o)}, 32'd0);
    endtask

    initial begin
        // Reset state
        apply_reset();
        step();
        check("reset_valid", {31'd0, trace_valid_o}, 32'd0);
        check("reset_cycle", cycle_cnt_o, 32'd0);
        check("reset_stall", stall_cnt_o, 32'd0);
        check("reset_flush", flush_cnt_o, 32'd0);
        check("reset_drop", {16'd0, drop_cnt_o}, 32'd0);

        // Basic stream
        trace_ready_i = 1'b1;
        start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_i = 32'(4 * i);
            push_rec(32'(i), 32'(4 * i), 32'd0, 32'd0);
            step();
        end
        start_i = 1'b0;
        drain("basic");
        check("basic_cycle_cnt", cycle_cnt_o, 32'd3);

        // Event gating: branch masks stall, then real stall, then flush
        start_i = 1'b1;
        pc_i = 32'h100; stall_i = 1'b1; branch_i = 1'b1; flush_i = 1'b0;
        push_rec(32'd3, 32'h100, 32'd0, 32'd0);
        step();
        pc_i = 32'h104; stall_i = 1'b1; branch_i = 1'b0; flush_i = 1'b0;
        push_rec(32'd4, 32'h104, 32'd1, 32'd0);
        step();
        pc_i = 32'h108; stall_i = 1'b0; branch_i = 1'b0; flush_i = 1'b1;
        push_rec(32'd5, 32'h108, 32'd1, 32'd1);
        step();
        start_i = 1'b0; flush_i = 1'b0;
        drain("gating");
        check("gating_stall_cnt", stall_cnt_o, 32'd1);
        check("gating_flush_cnt", flush_cnt_o, 32'd1);
        check("gating_cycle_cnt", cycle_cnt_o, 32'd6);

        // Backpressure and drop
        apply_reset();
        trace_ready_i = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pc_i = 32'(16 * (i + 1));
            if (i < DEPTH) push_rec(32'(i), 32'(16 * (i + 1)), 32'd0, 32'd0);
            step();
        end
        start_i = 1'b0;
        check("bp_drop_cnt", {16'd0, drop_cnt_o}, 32'd3);
        check("bp_cycle_cnt", cycle_cnt_o, 32'd7);
        check("bp_valid", {31'd0, trace_valid_o}, 32'd1);
        check("bp_head_data", trace_data_o, 32'd0);
        step();
        step();
        check("bp_head_hold_data", trace_data_o, 32'd0);
        check("bp_head_hold_word", {30'd0, trace_word_o}, 32'd0);

        // Full FIFO with head at word 3 and a simultaneous push
        trace_ready_i = 1'b1;
        step();
        step();
        step();
        trace_ready_i = 1'b0;
        check("full_head_word", {30'd0, trace_word_o}, 32'd3);
        check("full_head_last", {31'd0, trace_last_o}, 32'd1);
        trace_ready_i = 1'b1;
        start_i = 1'b1;
        pc_i = 32'h80;
        push_rec(32'd7, 32'h80, 32'd0, 32'd0);
        step();
        start_i = 1'b0;
        check("full_pop_push_drop", {16'd0, drop_cnt_o}, 32'd3);
        drain("full_pop_push");
        check("full_pop_push_cycle", cycle_cnt_o, 32'd8);

        // Reset in the middle of a record
        apply_reset();
        trace_ready_i = 1'b1;
        start_i = 1'b1;
        pc_i = 32'h200;
        push_rec(32'd0, 32'h200, 32'd0, 32'd0);
        step();
        start_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        q.delete();
        step();
        check("midrst_valid", {31'd0, trace_valid_o}, 32'd0);
        check("midrst_cycle", cycle_cnt_o, 32'd0);
        check("midrst_word", {30'd0, trace_word_o}, 32'd0);
        rst_i = 1'b1;
        start_i = 1'b1;
        pc_i = 32'h300;
        push_rec(32'd0, 32'h300, 32'd0, 32'd0);
        step();
        start_i = 1'b0;
        drain("midrst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
